// File: rtl/branch_target_table.sv
// Runtime-writable branch-target table for the fetch stage: absolute or PC-relative
// entries, registered one-cycle lookups, and a sequential self-clear after reset.
module branch_target_table #(
    parameter int D = 10,
    parameter int A = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         lookup_req,
    input  logic [A-1:0] lookup_addr,
    input  logic [D-1:0] pc,
    input  logic         wr_en,
    input  logic [A-1:0] wr_addr,
    input  logic [D-1:0] wr_target,
    input  logic         wr_rel,
    output logic         ready,
    output logic         target_valid,
    output logic [D-1:0] target,
    output logic         target_rel
);

    localparam int DEPTH = 2 ** A;
    localparam logic [A-1:0] LAST_IDX = A'(DEPTH - 1);
    localparam logic [A-1:0] IDX_ONE  = A'(1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t       state_r;
    logic [A-1:0] idx_r;
    logic [D:0]   mem_r [DEPTH];
    logic         ready_r;
    logic         target_valid_r;
    logic [D-1:0] target_r;
    logic         target_rel_r;

    logic [D:0]   rd_entry_s;
    logic [D-1:0] resolved_s;

    // Entry read with write-first bypass, then resolve relative offsets against pc
    always_comb begin
        rd_entry_s = '0;
        resolved_s = '0;
        if (wr_en && (wr_addr == lookup_addr)) begin
            rd_entry_s = {wr_rel, wr_target};
        end else begin
            rd_entry_s = mem_r[lookup_addr];
        end
        if (rd_entry_s[D]) begin
            resolved_s = pc + rd_entry_s[D-1:0];
        end else begin
            resolved_s = rd_entry_s[D-1:0];
        end
    end

    // Table storage: the clear sweep owns the write port until the FSM reaches RUN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_r == ST_INIT) begin
                mem_r[idx_r] <= '0;
            end else if (wr_en) begin
                mem_r[wr_addr] <= {wr_rel, wr_target};
            end
        end
    end

    // Control FSM and registered lookup result
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_INIT;
            idx_r          <= '0;
            ready_r        <= 1'b0;
            target_valid_r <= 1'b0;
            target_r       <= '0;
            target_rel_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    idx_r          <= idx_r + IDX_ONE;
                    target_valid_r <= 1'b0;
                    if (idx_r == LAST_IDX) begin
                        state_r <= ST_RUN;
                        ready_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    ready_r        <= 1'b1;
                    target_valid_r <= lookup_req;
                    if (lookup_req) begin
                        target_r     <= resolved_s;
                        target_rel_r <= rd_entry_s[D];
                    end
                end
                default: begin
                    state_r        <= ST_INIT;
                    idx_r          <= '0;
                    ready_r        <= 1'b0;
                    target_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign ready        = ready_r;
    assign target_valid = target_valid_r;
    assign target       = target_r;
    assign target_rel   = target_rel_r;

endmodule

// File: tb/tb_branch_target_table.sv
// Directed, table-driven bench for branch_target_table (D=10, A=4).
module tb_branch_target_table;

    logic       clk;
    logic       reset;
    logic       lookup_req;
    logic [3:0] lookup_addr;
    logic [9:0] pc;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [9:0] wr_target;
    logic       wr_rel;
    logic       ready;
    logic       target_valid;
    logic [9:0] target;
    logic       target_rel;

    int n_checks;
    int n_fail;

    branch_target_table #(.D(10), .A(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .lookup_req   (lookup_req),
        .lookup_addr  (lookup_addr),
        .pc           (pc),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_target    (wr_target),
        .wr_rel       (wr_rel),
        .ready        (ready),
        .target_valid (target_valid),
        .target       (target),
        .target_rel   (target_rel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       wr_en;
        logic [3:0] wr_addr;
        logic [9:0] wr_target;
        logic       wr_rel;
        logic       lk;
        logic [3:0] lk_addr;
        logic [9:0] pc;
        logic       exp_valid;
        logic [9:0] exp_target;
        logic       exp_rel;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [9:0] wt,
                                input logic wrel, input logic lk, input logic [3:0] la,
                                input logic [9:0] p, input logic ev, input logic [9:0] et,
                                input logic er);
        vec_t v;
        v.wr_en = we; v.wr_addr = wa; v.wr_target = wt; v.wr_rel = wrel;
        v.lk = lk; v.lk_addr = la; v.pc = p;
        v.exp_valid = ev; v.exp_target = et; v.exp_rel = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance one rising edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lookup_req = 1'b0; lookup_addr = 4'd0; pc = 10'd0;
        wr_en = 1'b0; wr_addr = 4'd0; wr_target = 10'd0; wr_rel = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        reset = 1'b1;

        vecs[0]  = mk(1'b1, 4'd3,  10'd121,  1'b0, 1'b0, 4'd0,  10'd0,    1'b0, 10'd0,    1'b0);
        vecs[1]  = mk(1'b0, 4'd0,  10'd0,    1'b0, 1'b1, 4'd3,  10'd500,  1'b1, 10'd121,  1'b0);
        vecs[2]  = mk(1'b1, 4'd9,  10'h3FB,  1'b1, 1'b0, 4'd0,  10'd0,    1'b0, 10'd121,  1'b0);
        vecs[3]  = mk(1'b0, 4'd0,  10'd0,    1'b0, 1'b1, 4'd9,  10'd4,    1'b1, 10'h3FF,  1'b1);
        vecs[4]  = mk(1'b1, 4'd9,  10'h014,  1'b1, 1'b0, 4'd0,  10'd0,    1'b0, 10'h3FF,  1'b1);
        vecs[5]  = mk(1'b0, 4'd0,  10'd0,    1'b0, 1'b1, 4'd9,  10'h3FE,  1'b1, 10'h012,  1'b1);
        vecs[6]  = mk(1'b1, 4'd8,  10'd99,   1'b0, 1'b1, 4'd7,  10'd0,    1'b1, 10'd0,    1'b0);
        vecs[7]  = mk(1'b1, 4'd7,  10'd61,   1'b0, 1'b1, 4'd7,  10'd0,    1'b1, 10'd61,   1'b0);
        vecs[8]  = mk(1'b0, 4'd0,  10'd0,    1'b0, 1'b1, 4'd8,  10'd0,    1'b1, 10'd99,   1'b0);
        vecs[9]  = mk(1'b1, 4'd10, 10'h3FB,  1'b1, 1'b1, 4'd10, 10'd10,   1'b1, 10'd5,    1'b1);
        vecs[10] = mk(1'b1, 4'd1,  10'd11,   1'b0, 1'b0, 4'd0,  10'd0,    1'b0, 10'd5,    1'b1);
        vecs[11] = mk(1'b1, 4'd2,  10'd80,   1'b0, 1'b0, 4'd0,  10'd0,    1'b0, 10'd5,    1'b1);
        vecs[12] = mk(1'b0, 4'd0,  10'd0,    1'b0, 1'b1, 4'd1,  10'd0,    1'b1, 10'd11,   1'b0);
        vecs[13] = mk(1'b0, 4'd0,  10'd0,    1'b0, 1'b1, 4'd2,  10'd0,    1'b1, 10'd80,   1'b0);
        vecs[14] = mk(1'b0, 4'd0,  10'd0,    1'b0, 1'b1, 4'd3,  10'd0,    1'b1, 10'd121,  1'b0);
        vecs[15] = mk(1'b0, 4'd0,  10'd0,    1'b0, 1'b1, 4'd1,  10'd0,    1'b1, 10'd11,   1'b0);
        vecs[16] = mk(1'b0, 4'd0,  10'd0,    1'b0, 1'b0, 4'd0,  10'd0,    1'b0, 10'd11,   1'b0);

        // Reset for two cycles, then hold a lookup of addr 5 through the clear sweep
        step();
        step();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_valid", 32'(target_valid), 32'd0);
        chk("rst_target", 32'(target), 32'd0);
        chk("rst_rel", 32'(target_rel), 32'd0);

        reset = 1'b0;
        lookup_req = 1'b1;
        lookup_addr = 4'd5;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("init_valid_e%0d", k), 32'(target_valid), 32'd0);
            chk($sformatf("init_ready_e%0d", k), 32'(ready), (k == 16) ? 32'd1 : 32'd0);
        end
        step();
        chk("first_run_valid", 32'(target_valid), 32'd1);
        chk("first_run_target", 32'(target), 32'd0);
        chk("first_run_rel", 32'(target_rel), 32'd0);

        // Table-driven functional vectors
        for (int i = 0; i < NVEC; i++) begin
            wr_en       = vecs[i].wr_en;
            wr_addr     = vecs[i].wr_addr;
            wr_target   = vecs[i].wr_target;
            wr_rel      = vecs[i].wr_rel;
            lookup_req  = vecs[i].lk;
            lookup_addr = vecs[i].lk_addr;
            pc          = vecs[i].pc;
            step();
            chk($sformatf("vec%0d_valid", i), 32'(target_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_target", i), 32'(target), 32'(vecs[i].exp_target));
            chk($sformatf("vec%0d_rel", i), 32'(target_rel), 32'(vecs[i].exp_rel));
        end

        // Reset mid-run on the same edge as a write and a lookup
        wr_en = 1'b1; wr_addr = 4'd2; wr_target = 10'd80; wr_rel = 1'b0;
        lookup_req = 1'b1; lookup_addr = 4'd2; pc = 10'd0;
        reset = 1'b1;
        step();
        chk("midrst_valid", 32'(target_valid), 32'd0);
        chk("midrst_ready", 32'(ready), 32'd0);
        chk("midrst_target", 32'(target), 32'd0);
        chk("midrst_rel", 32'(target_rel), 32'd0);

        // Reset again partway through the sweep; writes during the sweep are ignored
        reset = 1'b0;
        wr_addr = 4'd4; wr_target = 10'd77;
        for (int k = 0; k < 5; k++) step();
        chk("init_part_ready", 32'(ready), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("reinit_ready_e%0d", k), 32'(ready), (k == 16) ? 32'd1 : 32'd0);
        end
        wr_en = 1'b0;
        lookup_addr = 4'd2;
        step();
        chk("post_rst_a2_valid", 32'(target_valid), 32'd1);
        chk("post_rst_a2_target", 32'(target), 32'd0);
        lookup_addr = 4'd4;
        step();
        chk("init_wr_ignored_target", 32'(target), 32'd0);
        lookup_addr = 4'd3;
        step();
        chk("post_rst_a3_target", 32'(target), 32'd0);
        lookup_req = 1'b0;
        step();
        chk("post_rst_idle_valid", 32'(target_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
